// File: rtl/toggle_rx_pkg.sv
// Shared types and constants for the toggle-encoded serial receiver.
// TOGGLE_RX_PARITY_EN adds a trailing even-parity slot to every data byte.
package toggle_rx_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_e;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

`ifdef TOGGLE_RX_PARITY_EN
  localparam int BIT_SLOTS = 9;
`else
  localparam int BIT_SLOTS = 8;
`endif

  localparam int CNT_W = 4;

endpackage

// File: rtl/toggle_decode.sv
// Toggle decoder: a line transition is a 1, no transition is a 0.
// prev_line only advances on sample strobes and is cleared only by reset.
module toggle_decode (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_en,
  input  logic line_in,
  output logic d,
  output logic d_valid
);

  logic prev_line_q;
  logic prev_line_d;

  always_comb begin
    prev_line_d = prev_line_q;
    if (bit_en) begin
      prev_line_d = line_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_line_q <= 1'b0;
    end else begin
      prev_line_q <= prev_line_d;
    end
  end

  assign d       = line_in ^ prev_line_q;
  assign d_valid = bit_en;

endmodule

// File: rtl/toggle_rx.sv
// Toggle-line receiver: hunts for SYNC_WORD, then deserialises FRAME_LEN bytes.
// Build option TOGGLE_RX_PARITY_EN: 9 slots per byte, last slot is even parity.
//
// state | meaning
// HUNT  | shifting decoded bits into the sync window, waiting for SYNC_WORD
// DATA  | assembling payload bytes until FRAME_LEN have been delivered
module toggle_rx
  import toggle_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int                FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              line_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              in_frame,
  output logic              frame_done,
  output logic              parity_err
);

  // The newest decoded bit completes both the window and the byte, so only
  // the older bits need storage.
  localparam int SHREG_W = BIT_SLOTS - 1;

  logic d;
  logic d_valid;

  state_e              state_q,      state_d;
  logic [BYTE_W-2:0]   window_q,     window_d;
  logic [SHREG_W-1:0]  shreg_q,      shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [7:0]          bytes_left_q, bytes_left_d;
  logic [BYTE_W-1:0]   data_out_q,   data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                parity_err_q, parity_err_d;
  logic                byte_done;

  toggle_decode u_decode (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_en  (bit_en),
    .line_in (line_in),
    .d       (d),
    .d_valid (d_valid)
  );

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    parity_err_d = 1'b0;
    byte_done    = 1'b0;

    if (d_valid) begin
      case (state_q)
        HUNT: begin
          window_d = {window_q[BYTE_W-3:0], d};
          if ({window_q, d} == SYNC_WORD) begin
            state_d      = DATA;
            window_d     = '0;
            shreg_d      = '0;
            bit_cnt_d    = CNT_W'(BIT_SLOTS - 1);
            bytes_left_d = 8'(FRAME_LEN - 1);
          end
        end
        DATA: begin
          if (bit_cnt_q == '0) begin
            byte_done = 1'b1;
`ifdef TOGGLE_RX_PARITY_EN
            data_out_d   = shreg_q;
            parity_err_d = ^{shreg_q, d};
`else
            data_out_d   = {shreg_q, d};
`endif
          end else begin
            shreg_d   = {shreg_q[SHREG_W-2:0], d};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (byte_done) begin
      data_valid_d = 1'b1;
      shreg_d      = '0;
      bit_cnt_d    = CNT_W'(BIT_SLOTS - 1);
      if (bytes_left_q == 8'd0) begin
        frame_done_d = 1'b1;
        state_d      = HUNT;
        window_d     = '0;
      end else begin
        bytes_left_d = bytes_left_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      window_q     <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      bytes_left_q <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_left_q <= bytes_left_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_done = frame_done_q;
  assign in_frame   = (state_q == DATA);
`ifdef TOGGLE_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_rx.sv
// Scoreboard bench for toggle_rx with FRAME_LEN=2; honours TOGGLE_RX_PARITY_EN.
module tb_toggle_rx;

  typedef struct packed {
    logic [7:0] b;
    logic       fd;
    logic       pe;
  } exp_t;

  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       line_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       in_frame;
  logic       frame_done;
  logic       parity_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   gap      = 0;
  logic line_st  = 1'b0;
  logic en_q     = 1'b0;

  toggle_rx #(.SYNC_WORD(SYNC), .FRAME_LEN(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .line_in    (line_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .in_frame   (in_frame),
    .frame_done (frame_done),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) en_q <= bit_en;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Any pulse must be a data_valid directly following a strobe, and match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (data_valid || frame_done || parity_err)) begin
      exp_t e;
      check_eq("dv_with_pulse", {31'd0, data_valid}, 32'd1);
      check_eq("dv_after_strobe", {31'd0, en_q}, 32'd1);
      check_eq("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("data_out", {24'd0, data_out}, {24'd0, e.b});
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
        check_eq("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
      end
    end
  end

  task automatic send_bit(input logic b);
    line_st = line_st ^ b;
    line_in = line_st;
    bit_en  = 1'b1;
    @(negedge clk);
    bit_en  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = SYNC;
    for (int i = 7; i >= 1; i--) send_bit(s[i]);
    check_eq("in_frame_pre_sync", {31'd0, in_frame}, 32'd0);
    send_bit(s[0]);
    check_eq("in_frame_sync", {31'd0, in_frame}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic par_zero);
    logic par;
    exp_t e;
    par  = par_zero ? 1'b0 : ^b;
    e.b  = b;
    e.fd = last;
`ifdef TOGGLE_RX_PARITY_EN
    e.pe = (^b) ^ par;
`else
    e.pe = 1'b0;
`endif
    sb.push_back(e);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
`ifdef TOGGLE_RX_PARITY_EN
    send_bit(par);
`endif
  endtask

  task automatic finish_frame(input logic [7:0] last_b);
    repeat (3) @(negedge clk);
    check_eq("in_frame_end", {31'd0, in_frame}, 32'd0);
    check_eq("sb_drained", sb.size(), 32'd0);
    check_eq("data_out_hold", {24'd0, data_out}, {24'd0, last_b});
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    check_eq({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
    check_eq({tag, "_in_frame"}, {31'd0, in_frame}, 32'd0);
    check_eq({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    check_eq({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    bit_en  = 1'b0;
    line_in = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Contiguous strobes
    gap = 0;
    send_sync();
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    finish_frame(8'hFF);

    // Strobe every third cycle
    gap = 2;
    send_sync();
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    finish_frame(8'hFF);

    // Sync pattern as payload
    gap = 1;
    send_sync();
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    finish_frame(8'h12);

    // Reset after three bits of the second byte
    gap = 0;
    send_sync();
    send_byte(8'h11, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    rst_n   = 1'b1;
    line_st = 1'b0;
    line_in = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check_eq("midrst_hunt", {31'd0, in_frame}, 32'd0);
    send_sync();
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    finish_frame(8'hC3);

`ifdef TOGGLE_RX_PARITY_EN
    send_sync();
    send_byte(8'h03, 1'b0, 1'b1);
    send_byte(8'h07, 1'b1, 1'b1);
    finish_frame(8'h07);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
